// File: rtl/fwd_regfile_if.sv
// Register-file bus between the ID stage (master) and fwd_regfile (slave).
// Carries the three forwarding/write sources (EX, MEM, WB), the packed
// read ports and the load-use stall request.
//   ex_*      : EX-stage result, destination, load flag
//   mem_*     : MEM-stage result and destination
//   we/waddr/wdata : WB write port (the only source that updates the array)
//   re/raddr  : per-port read enable and packed read addresses
//   rdata     : packed read data, port i at [i*DW +: DW]
//   stall_req : load-use hazard on any enabled port
interface fwd_regfile_if #(
   parameter int DW  = 32,
   parameter int AW  = 5,
   parameter int NRD = 2
);
   logic              ex_we;
   logic              ex_is_load;
   logic [AW-1:0]     ex_waddr;
   logic [DW-1:0]     ex_wdata;
   logic              mem_we;
   logic [AW-1:0]     mem_waddr;
   logic [DW-1:0]     mem_wdata;
   logic              we;
   logic [AW-1:0]     waddr;
   logic [DW-1:0]     wdata;
   logic [NRD-1:0]    re;
   logic [NRD*AW-1:0] raddr;
   logic [NRD*DW-1:0] rdata;
   logic              stall_req;

   modport master (
      output ex_we, ex_is_load, ex_waddr, ex_wdata,
      output mem_we, mem_waddr, mem_wdata,
      output we, waddr, wdata, re, raddr,
      input  rdata, stall_req
   );

   modport slave (
      input  ex_we, ex_is_load, ex_waddr, ex_wdata,
      input  mem_we, mem_waddr, mem_wdata,
      input  we, waddr, wdata, re, raddr,
      output rdata, stall_req
   );
endinterface

// File: rtl/fwd_regfile.sv
// Multi-port register file with EX/MEM/WB result forwarding and load-use
// stall detection. Reads are combinational; only the WB port writes the array.
// Ports:
//   clk       : clock, state updates on rising edge
//   rst       : asynchronous active-low reset, clears the array (and counters)
//   bus       : fwd_regfile_if.slave (forwarding sources, reads, stall_req)
//   fwd_cnt   : 64-bit statistics, only when FWD_CNT_EN is defined
// Optional feature macro: FWD_CNT_EN -- four 16-bit saturating counters
//   [15:0] EX-forward cycles, [31:16] MEM-forward cycles,
//   [47:32] WB-forward cycles, [63:48] stall_req cycles.
module fwd_regfile #(
   parameter int DW  = 32,
   parameter int AW  = 5,
   parameter int NRD = 2
) (
   input logic            clk,
   input logic            rst,
   fwd_regfile_if.slave   bus
`ifdef FWD_CNT_EN
   ,
   output logic [63:0]    fwd_cnt
`endif
);
   localparam int NREG = 1 << AW;

   logic [NREG-1:0][DW-1:0] regs_q, regs_d;
   logic [NRD-1:0][DW-1:0]  rdata_c;
   logic [NRD-1:0]          rd_act;
   logic [NRD-1:0]          hit_ex, hit_mem, hit_wb;
   logic [NRD-1:0]          hazard;

   always_comb begin
      regs_d = regs_q;
      if (bus.we && (bus.waddr != '0)) regs_d[bus.waddr] = bus.wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) regs_q <= '0;
      else      regs_q <= regs_d;
   end

   // Hit flags are made mutually exclusive here so the mux below and the
   // statistics counters see the same youngest-wins source per port.
   for (genvar g = 0; g < NRD; g++) begin : g_port
      logic [AW-1:0] ra;
      assign ra         = bus.raddr[g*AW +: AW];
      assign rd_act[g]  = bus.re[g] && (ra != '0);
      assign hit_ex[g]  = rd_act[g] && bus.ex_we && (bus.ex_waddr == ra);
      assign hit_mem[g] = rd_act[g] && !hit_ex[g] && bus.mem_we && (bus.mem_waddr == ra);
      assign hit_wb[g]  = rd_act[g] && !hit_ex[g] && !hit_mem[g] && bus.we && (bus.waddr == ra);
      assign hazard[g]  = hit_ex[g] && bus.ex_is_load;
      assign rdata_c[g] = !rd_act[g] ? '0            :
                          hit_ex[g]  ? bus.ex_wdata  :
                          hit_mem[g] ? bus.mem_wdata :
                          hit_wb[g]  ? bus.wdata     :
                                       regs_q[ra];
   end

   assign bus.rdata     = rdata_c;
   assign bus.stall_req = |hazard;

`ifdef FWD_CNT_EN
   // A load hit in EX is a stall, not a forward, so it is not counted as one.
   logic [3:0][15:0] cnt_q, cnt_d;
   logic [3:0]       cnt_inc;

   assign cnt_inc = {|hazard, |hit_wb, |hit_mem, |(hit_ex & ~hazard)};

   always_comb begin
      cnt_d = cnt_q;
      for (int k = 0; k < 4; k++) begin
         if (cnt_inc[k] && (cnt_q[k] != 16'hFFFF)) cnt_d[k] = cnt_q[k] + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign fwd_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_fwd_regfile.sv
module tb_fwd_regfile;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fwd_regfile_if #(.DW(32), .AW(5), .NRD(2)) bus ();

`ifdef FWD_CNT_EN
   logic [63:0] fwd_cnt;
   fwd_regfile #(.DW(32), .AW(5), .NRD(2)) dut (.clk(clk), .rst(rst), .bus(bus), .fwd_cnt(fwd_cnt));
`else
   fwd_regfile #(.DW(32), .AW(5), .NRD(2)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   typedef struct {
      logic        ex_we;  logic ex_ld; logic [4:0] ex_a;  logic [31:0] ex_d;
      logic        mem_we; logic [4:0] mem_a; logic [31:0] mem_d;
      logic        we;     logic [4:0] wa;    logic [31:0] wd;
      logic [1:0]  re;     logic [4:0] ra0;   logic [4:0]  ra1;
      logic        c0;     logic [31:0] e0;   logic [31:0] e1; logic es;
   } vec_t;

   vec_t vecs [14];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic idle();
      bus.ex_we = 0; bus.ex_is_load = 0; bus.ex_waddr = 0; bus.ex_wdata = 0;
      bus.mem_we = 0; bus.mem_waddr = 0; bus.mem_wdata = 0;
      bus.we = 0; bus.waddr = 0; bus.wdata = 0;
      bus.re = 0; bus.raddr = 0;
   endtask

   function automatic logic [31:0] rd(input int p);
      logic [63:0] r;
      r = bus.rdata;
      return (p == 0) ? r[31:0] : r[63:32];
   endfunction

   initial begin
      // ex_we ld ex_a ex_d | mem_we mem_a mem_d | we wa wd | re ra0 ra1 | c0 e0 e1 stall
      vecs[0]  = '{0,0,5'd0,32'h0,        0,5'd0,32'h0,    0,5'd0,32'h0,          2'b11,5'd3,5'd5, 1,32'h0,32'h0,0};
      vecs[1]  = '{0,0,5'd0,32'h0,        0,5'd0,32'h0,    1,5'd2,32'h1234,       2'b11,5'd2,5'd2, 1,32'h1234,32'h1234,0};
      vecs[2]  = '{1,0,5'd2,32'h5678,     1,5'd2,32'h9ABC, 0,5'd0,32'h0,          2'b11,5'd2,5'd2, 1,32'h5678,32'h5678,0};
      vecs[3]  = '{0,0,5'd0,32'h0,        1,5'd2,32'h9ABC, 0,5'd0,32'h0,          2'b11,5'd2,5'd2, 1,32'h9ABC,32'h9ABC,0};
      vecs[4]  = '{0,0,5'd0,32'h0,        0,5'd0,32'h0,    0,5'd0,32'h0,          2'b11,5'd2,5'd2, 1,32'h1234,32'h1234,0};
      vecs[5]  = '{1,0,5'd3,32'hFFFF,     0,5'd0,32'h0,    0,5'd0,32'h0,          2'b11,5'd2,5'd3, 1,32'h1234,32'hFFFF,0};
      vecs[6]  = '{0,0,5'd0,32'h0,        0,5'd0,32'h0,    0,5'd0,32'h0,          2'b11,5'd3,5'd2, 1,32'h0,32'h1234,0};
      vecs[7]  = '{1,1,5'd4,32'h44,       0,5'd0,32'h0,    0,5'd0,32'h0,          2'b11,5'd4,5'd2, 0,32'h0,32'h1234,1};
      vecs[8]  = '{1,0,5'd4,32'h44,       0,5'd0,32'h0,    0,5'd0,32'h0,          2'b11,5'd4,5'd2, 1,32'h44,32'h1234,0};
      vecs[9]  = '{1,1,5'd4,32'h44,       0,5'd0,32'h0,    0,5'd0,32'h0,          2'b00,5'd4,5'd4, 1,32'h0,32'h0,0};
      vecs[10] = '{1,1,5'd0,32'hDEADBEEF, 0,5'd0,32'h0,    1,5'd0,32'hDEADBEEF,   2'b11,5'd0,5'd0, 1,32'h0,32'h0,0};
      vecs[11] = '{0,0,5'd0,32'h0,        0,5'd0,32'h0,    0,5'd0,32'h0,          2'b11,5'd0,5'd2, 1,32'h0,32'h1234,0};
      vecs[12] = '{0,0,5'd0,32'h0,        1,5'd6,32'h66,   1,5'd5,32'h11,         2'b11,5'd6,5'd5, 1,32'h66,32'h11,0};
      vecs[13] = '{0,0,5'd0,32'h0,        0,5'd0,32'h0,    0,5'd0,32'h0,          2'b11,5'd6,5'd5, 1,32'h0,32'h11,0};

      idle();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      bus.re = 2'b11; bus.raddr = {5'd7, 5'd1};
      #1;
      chk("reset_rd0", rd(0), 0);
      chk("reset_rd1", rd(1), 0);
      chk("reset_stall", bus.stall_req, 0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         bus.ex_we = vecs[i].ex_we;   bus.ex_is_load = vecs[i].ex_ld;
         bus.ex_waddr = vecs[i].ex_a; bus.ex_wdata = vecs[i].ex_d;
         bus.mem_we = vecs[i].mem_we; bus.mem_waddr = vecs[i].mem_a; bus.mem_wdata = vecs[i].mem_d;
         bus.we = vecs[i].we; bus.waddr = vecs[i].wa; bus.wdata = vecs[i].wd;
         bus.re = vecs[i].re; bus.raddr = {vecs[i].ra1, vecs[i].ra0};
         #1;
         if (vecs[i].c0) chk($sformatf("vec%0d_rd0", i), rd(0), vecs[i].e0);
         chk($sformatf("vec%0d_rd1", i), rd(1), vecs[i].e1);
         chk($sformatf("vec%0d_stall", i), bus.stall_req, vecs[i].es);
      end

      // Asynchronous reset in mid-cycle: r5 (0x11) must clear without a clock edge.
      @(negedge clk);
      idle();
      bus.re = 2'b11; bus.raddr = {5'd2, 5'd5};
      #1;
      chk("pre_rst_r5", rd(0), 32'h11);
      #1;
      rst = 1'b0;
      #1;
      chk("async_rst_r5", rd(0), 0);
      chk("async_rst_r2", rd(1), 0);

      // Forwarding and stall still work while in reset; WB write is dropped.
      bus.ex_we = 1; bus.ex_waddr = 5'd5; bus.ex_wdata = 32'h77;
      bus.we = 1; bus.waddr = 5'd7; bus.wdata = 32'h99;
      bus.raddr = {5'd7, 5'd5};
      #1;
      chk("rst_fwd_ex", rd(0), 32'h77);
      chk("rst_fwd_wb", rd(1), 32'h99);
      bus.ex_is_load = 1;
      #1;
      chk("rst_stall", bus.stall_req, 1);
      @(posedge clk);
      @(negedge clk);
      idle();
      rst = 1'b1;
      bus.re = 2'b01; bus.raddr = {5'd0, 5'd7};
      #1;
      chk("rst_write_dropped", rd(0), 0);
      bus.we = 1; bus.waddr = 5'd7; bus.wdata = 32'hA5A5;
      @(negedge clk);
      bus.we = 0;
      #1;
      chk("post_rst_write", rd(0), 32'hA5A5);

`ifdef FWD_CNT_EN
      @(negedge clk);
      idle();
      rst = 1'b0;
      #1;
      chk("cnt_reset", fwd_cnt, 64'h0);
      @(negedge clk);
      rst = 1'b1;
      bus.ex_we = 1; bus.ex_waddr = 5'd3; bus.ex_wdata = 32'h1;
      bus.re = 2'b01; bus.raddr = {5'd0, 5'd3};
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("cnt_ex_5", fwd_cnt, 64'h5);
      repeat (70000) @(posedge clk);
      @(negedge clk);
      chk("cnt_ex_sat", fwd_cnt, 64'h0000_0000_0000_FFFF);
      idle();
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
